// File: rtl/avalon_aes_mc_regfile.sv
// avalon_aes_mc_regfile
//
// Multi-channel Avalon-MM register front end for a shared AES core.
// It holds NUM_CH independent contexts. Each context has a key, a message,
// a result, a mode bit, an interrupt enable and the status flags. A
// round-robin arbiter issues pending jobs to the core one at a time.
//
// Parameters
//   NUM_CH  number of contexts (power of two, 1..16)
//   CH_W    log2(NUM_CH)
//
// Ports
//   CLK, RESET_N              clock (rising edge), asynchronous active-low reset
//   AVL_CS/READ/WRITE         Avalon-MM strobes (CS qualifies READ and WRITE)
//   AVL_ADDR                  {channel, word[3:0]}
//   AVL_BYTE_EN/WRITEDATA     byte-merged write data
//   AVL_READDATA              registered read data, latency 1, 0 after a non-read
//   CORE_VALID/CORE_READY     job handshake to the AES core
//   CORE_KEY/CORE_MSG/MODE    context of the granted channel
//   CORE_DONE/CORE_RESULT     one-cycle completion pulse with the result block
//   IRQ                       registered OR of (DONE & IRQ_EN) over channels
//   EXPORT_DATA               {ch0 w0[31:16], ch0 w3[15:0]} for the LED conduit
//
// Word map per channel: 0-3 key, 4-7 message, 8-11 result (RO), 12 CTRL,
// 13 STATUS, 14 reserved, 15 IRQ summary (RO).
module avalon_aes_mc_regfile #(
    parameter int NUM_CH = 4,
    parameter int CH_W   = 2
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             AVL_READ,
    input  logic             AVL_WRITE,
    input  logic             AVL_CS,
    input  logic [3:0]       AVL_BYTE_EN,
    input  logic [CH_W+3:0]  AVL_ADDR,
    input  logic [31:0]      AVL_WRITEDATA,
    output logic [31:0]      AVL_READDATA,
    output logic             CORE_VALID,
    input  logic             CORE_READY,
    output logic [127:0]     CORE_KEY,
    output logic [127:0]     CORE_MSG,
    output logic             CORE_MODE,
    input  logic             CORE_DONE,
    input  logic [127:0]     CORE_RESULT,
    output logic             IRQ,
    output logic [31:0]      EXPORT_DATA
);

    // Channel index width; a single-channel build still needs a 1-bit index.
    localparam int CI_W = (CH_W > 0) ? CH_W : 1;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_WAIT
    } arb_state_t;

    // Context storage
    logic [31:0]       data_reg   [NUM_CH][8];   // words 0-7: key then message
    logic [31:0]       result_reg [NUM_CH][4];   // words 8-11
    logic [NUM_CH-1:0] mode_reg;
    logic [NUM_CH-1:0] irq_en_reg;
    logic [NUM_CH-1:0] pending_reg;
    logic [NUM_CH-1:0] busy_reg;
    logic [NUM_CH-1:0] done_reg;
    logic [NUM_CH-1:0] werr_reg;

    logic [31:0]       readdata_reg;
    logic [31:0]       readdata_next;
    logic              irq_reg;
    logic [NUM_CH-1:0] irq_vec;

    // Arbiter state
    arb_state_t        arb_state_reg;
    arb_state_t        arb_state_next;
    logic [CI_W-1:0]   grant_reg;       // channel held in REQ/WAIT
    logic [CI_W-1:0]   last_reg;        // last granted channel
    logic              cool_reg;        // one idle cycle after each completion
    logic [CI_W-1:0]   sel_ch;
    logic              sel_found;
    logic [CI_W-1:0]   cur_ch;          // channel presented to the core
    logic              grant_now;
    logic              accept;
    logic              finish;

    // Bus decode
    logic              wr_en;
    logic              rd_en;
    logic [CI_W-1:0]   avl_ch;
    logic [3:0]        avl_word;
    logic              ch_prot;

    generate
        if (CH_W > 0) begin : g_ch_addr
            assign avl_ch = AVL_ADDR[CH_W+3:4];
        end else begin : g_ch_single
            assign avl_ch = '0;
        end
    endgenerate

    assign avl_word = AVL_ADDR[3:0];
    assign wr_en    = AVL_CS & AVL_WRITE;
    assign rd_en    = AVL_CS & AVL_READ;
    // Context of a queued or running job must not change under the core.
    assign ch_prot  = pending_reg[avl_ch] | busy_reg[avl_ch];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_irq
            assign irq_vec[gi] = done_reg[gi] & irq_en_reg[gi];
        end
    endgenerate

    function automatic logic [31:0] byte_merge(
        input logic [31:0] old_val,
        input logic [31:0] new_val,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_val;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) res[8*b +: 8] = new_val[8*b +: 8];
        end
        return res;
    endfunction

    // Round-robin search starting one above the last grant.
    always_comb begin
        int idx;
        idx       = 0;
        sel_found = 1'b0;
        sel_ch    = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            idx = (int'(last_reg) + 1 + i) % NUM_CH;
            if (!sel_found && pending_reg[idx]) begin
                sel_found = 1'b1;
                sel_ch    = CI_W'(idx);
            end
        end
    end

    // Arbiter next state and core handshake. CORE_VALID rises combinationally
    // in IDLE so a job started in cycle t is offered in t+1; a READY seen in
    // that same cycle is a valid handshake and goes straight to WAIT.
    always_comb begin
        arb_state_next = arb_state_reg;
        CORE_VALID     = 1'b0;
        cur_ch         = grant_reg;
        grant_now      = 1'b0;
        accept         = 1'b0;
        finish         = 1'b0;
        case (arb_state_reg)
            ARB_IDLE: begin
                if (sel_found && !cool_reg) begin
                    CORE_VALID = 1'b1;
                    cur_ch     = sel_ch;
                    grant_now  = 1'b1;
                    if (CORE_READY) begin
                        accept         = 1'b1;
                        arb_state_next = ARB_WAIT;
                    end else begin
                        arb_state_next = ARB_REQ;
                    end
                end
            end
            ARB_REQ: begin
                CORE_VALID = 1'b1;
                if (CORE_READY) begin
                    accept         = 1'b1;
                    arb_state_next = ARB_WAIT;
                end
            end
            ARB_WAIT: begin
                if (CORE_DONE) begin
                    finish         = 1'b1;
                    arb_state_next = ARB_IDLE;
                end
            end
            default: arb_state_next = ARB_IDLE;
        endcase
    end

    assign CORE_KEY  = {data_reg[cur_ch][0], data_reg[cur_ch][1],
                        data_reg[cur_ch][2], data_reg[cur_ch][3]};
    assign CORE_MSG  = {data_reg[cur_ch][4], data_reg[cur_ch][5],
                        data_reg[cur_ch][6], data_reg[cur_ch][7]};
    assign CORE_MODE = mode_reg[cur_ch];

    // Read mux: sampled from current state, so a same-cycle write is not seen.
    always_comb begin
        readdata_next = '0;
        if (!avl_word[3]) begin
            readdata_next = data_reg[avl_ch][avl_word[2:0]];
        end else begin
            case (avl_word[2:0])
                3'd0, 3'd1, 3'd2, 3'd3:
                    readdata_next = result_reg[avl_ch][avl_word[1:0]];
                3'd4: readdata_next = {29'd0, irq_en_reg[avl_ch], mode_reg[avl_ch], 1'b0};
                3'd5: readdata_next = {28'd0, werr_reg[avl_ch], pending_reg[avl_ch],
                                       busy_reg[avl_ch], done_reg[avl_ch]};
                3'd7: readdata_next = 32'(irq_vec);
                default: readdata_next = '0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            for (int c = 0; c < NUM_CH; c++) begin
                for (int w = 0; w < 8; w++) data_reg[c][w] <= '0;
                for (int w = 0; w < 4; w++) result_reg[c][w] <= '0;
            end
            mode_reg      <= '0;
            irq_en_reg    <= '0;
            pending_reg   <= '0;
            busy_reg      <= '0;
            done_reg      <= '0;
            werr_reg      <= '0;
            readdata_reg  <= '0;
            irq_reg       <= 1'b0;
            arb_state_reg <= ARB_IDLE;
            grant_reg     <= '0;
            last_reg      <= CI_W'(NUM_CH - 1);
            cool_reg      <= 1'b0;
        end else begin
            readdata_reg <= rd_en ? readdata_next : 32'd0;
            irq_reg      <= |irq_vec;

            // Bus writes first; arbiter updates below take priority on overlap.
            if (wr_en) begin
                if (!avl_word[3]) begin
                    if (ch_prot) begin
                        werr_reg[avl_ch] <= 1'b1;
                    end else begin
                        data_reg[avl_ch][avl_word[2:0]] <=
                            byte_merge(data_reg[avl_ch][avl_word[2:0]], AVL_WRITEDATA, AVL_BYTE_EN);
                    end
                end else if (avl_word[2:0] == 3'd4 && AVL_BYTE_EN[0]) begin
                    irq_en_reg[avl_ch] <= AVL_WRITEDATA[2];
                    // A locked MODE only flags an error if the write tries to change it.
                    if (!ch_prot) begin
                        mode_reg[avl_ch] <= AVL_WRITEDATA[1];
                    end else if (AVL_WRITEDATA[1] != mode_reg[avl_ch]) begin
                        werr_reg[avl_ch] <= 1'b1;
                    end
                    if (AVL_WRITEDATA[0] && !ch_prot) begin
                        pending_reg[avl_ch] <= 1'b1;
                        done_reg[avl_ch]    <= 1'b0;
                    end
                end else if (avl_word[2:0] == 3'd5 && AVL_BYTE_EN[0]) begin
                    if (AVL_WRITEDATA[0]) done_reg[avl_ch] <= 1'b0;
                    if (AVL_WRITEDATA[3]) werr_reg[avl_ch] <= 1'b0;
                end
            end

            arb_state_reg <= arb_state_next;
            cool_reg      <= finish;
            if (grant_now) begin
                grant_reg <= cur_ch;
                last_reg  <= cur_ch;
            end
            if (accept) begin
                pending_reg[cur_ch] <= 1'b0;
                busy_reg[cur_ch]    <= 1'b1;
            end
            if (finish) begin
                for (int w = 0; w < 4; w++) begin
                    result_reg[grant_reg][w] <= CORE_RESULT[127-32*w -: 32];
                end
                done_reg[grant_reg] <= 1'b1;
                busy_reg[grant_reg] <= 1'b0;
            end
        end
    end

    assign AVL_READDATA = readdata_reg;
    assign IRQ          = irq_reg;
    assign EXPORT_DATA  = {data_reg[0][0][31:16], data_reg[0][3][15:0]};

endmodule

// File: tb/tb_avalon_aes_mc_regfile.sv
// Directed testbench for avalon_aes_mc_regfile (NUM_CH = 4).
// Inputs are driven right after falling edges; outputs are sampled on
// falling edges, away from the active rising edge.
module tb_avalon_aes_mc_regfile;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 2;

    logic          CLK;
    logic          RESET_N;
    logic          AVL_READ;
    logic          AVL_WRITE;
    logic          AVL_CS;
    logic [3:0]    AVL_BYTE_EN;
    logic [CH_W+3:0] AVL_ADDR;
    logic [31:0]   AVL_WRITEDATA;
    logic [31:0]   AVL_READDATA;
    logic          CORE_VALID;
    logic          CORE_READY;
    logic [127:0]  CORE_KEY;
    logic [127:0]  CORE_MSG;
    logic          CORE_MODE;
    logic          CORE_DONE;
    logic [127:0]  CORE_RESULT;
    logic          IRQ;
    logic [31:0]   EXPORT_DATA;

    int n_cmp;
    int n_err;

    localparam logic [127:0] KEY2 = 128'h2B7E151628AED2A6ABF7158809CF4F3C;
    localparam logic [127:0] MSG2 = 128'h6BC1BEE22E409F96E93D7E117393172A;
    localparam logic [127:0] RES2 = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [127:0] RES3 = 128'h33333333444444445555555566666666;

    avalon_aes_mc_regfile #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .AVL_READ(AVL_READ), .AVL_WRITE(AVL_WRITE), .AVL_CS(AVL_CS),
        .AVL_BYTE_EN(AVL_BYTE_EN), .AVL_ADDR(AVL_ADDR),
        .AVL_WRITEDATA(AVL_WRITEDATA), .AVL_READDATA(AVL_READDATA),
        .CORE_VALID(CORE_VALID), .CORE_READY(CORE_READY),
        .CORE_KEY(CORE_KEY), .CORE_MSG(CORE_MSG), .CORE_MODE(CORE_MODE),
        .CORE_DONE(CORE_DONE), .CORE_RESULT(CORE_RESULT),
        .IRQ(IRQ), .EXPORT_DATA(EXPORT_DATA)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic avl_write(input logic [1:0] ch, input logic [3:0] word,
                             input logic [31:0] data, input logic [3:0] be);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = {ch, word};
        AVL_WRITEDATA = data; AVL_BYTE_EN = be;
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0; AVL_WRITEDATA = '0;
        $display("write ch%0d w%0d <= %08h be=%b", ch, word, data, be);
    endtask

    task automatic avl_read(input logic [1:0] ch, input logic [3:0] word,
                            output logic [31:0] data);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = {ch, word};
        @(negedge CLK);
        data = AVL_READDATA;
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        $display("read  ch%0d w%0d -> %08h", ch, word, data);
    endtask

    task automatic core_accept();
        CORE_READY = 1'b1;
        @(negedge CLK);
        CORE_READY = 1'b0;
        $display("core accepted job");
    endtask

    task automatic core_finish(input logic [127:0] res);
        CORE_DONE = 1'b1; CORE_RESULT = res;
        @(negedge CLK);
        CORE_DONE = 1'b0; CORE_RESULT = '0;
        $display("core done result=%032h", res);
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (CORE_VALID) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        n_cmp++;
        if (CORE_VALID !== 1'b0 || IRQ !== 1'b0 || AVL_READDATA !== 32'h0) begin
            n_err++;
            $display("FAIL reset_outputs: valid=%b irq=%b rdata=%h required 0/0/0", CORE_VALID, IRQ, AVL_READDATA);
        end
        n_cmp++;
        if (CORE_KEY !== 128'h0 || CORE_MSG !== 128'h0 || CORE_MODE !== 1'b0 || EXPORT_DATA !== 32'h0) begin
            n_err++;
            $display("FAIL reset_core_bus: key=%h msg=%h mode=%b export=%h required all 0", CORE_KEY, CORE_MSG, CORE_MODE, EXPORT_DATA);
        end
        for (int w = 0; w < 16; w++) begin
            avl_read(2'd0, 4'(w), rd);
            n_cmp++;
            if (rd !== 32'h0) begin
                n_err++;
                $display("FAIL reset_word%0d: got %h required 00000000", w, rd);
            end
        end
    endtask

    task automatic test_byte_enable();
        avl_write(2'd1, 4'd0, 32'hFFFF_FFFF, 4'b0101);
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = {2'd1, 4'd0};
        n_cmp++;
        if (AVL_READDATA !== 32'h0) begin
            n_err++;
            $display("FAIL rdata_before_latency: got %h required 00000000", AVL_READDATA);
        end
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_READ = 1'b0;
        n_cmp++;
        if (AVL_READDATA !== 32'h00FF_00FF) begin
            n_err++;
            $display("FAIL byte_enable_merge: got %h required 00ff00ff", AVL_READDATA);
        end
        @(negedge CLK);
        n_cmp++;
        if (AVL_READDATA !== 32'h0) begin
            n_err++;
            $display("FAIL rdata_after_nonread: got %h required 00000000", AVL_READDATA);
        end
    endtask

    task automatic test_single_job();
        logic [31:0] rd;
        for (int w = 0; w < 4; w++) avl_write(2'd2, 4'(w), KEY2[127-32*w -: 32], 4'hF);
        for (int w = 0; w < 4; w++) avl_write(2'd2, 4'(w+4), MSG2[127-32*w -: 32], 4'hF);
        avl_write(2'd2, 4'd12, 32'h3, 4'hF);
        n_cmp++;
        if (CORE_VALID !== 1'b1 || CORE_KEY !== KEY2 || CORE_MSG !== MSG2 || CORE_MODE !== 1'b1) begin
            n_err++;
            $display("FAIL job_request: valid=%b key=%h msg=%h mode=%b required 1/%h/%h/1", CORE_VALID, CORE_KEY, CORE_MSG, CORE_MODE, KEY2, MSG2);
        end
        repeat (3) @(negedge CLK);
        n_cmp++;
        if (CORE_VALID !== 1'b1 || CORE_KEY !== KEY2) begin
            n_err++;
            $display("FAIL job_request_held: valid=%b key=%h required 1/%h", CORE_VALID, CORE_KEY, KEY2);
        end
        core_accept();
        n_cmp++;
        if (CORE_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL valid_after_accept: got %b required 0", CORE_VALID);
        end
        avl_read(2'd2, 4'd13, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_err++;
            $display("FAIL status_busy: got %h required 00000002", rd);
        end
        avl_read(2'd2, 4'd12, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_err++;
            $display("FAIL ctrl_readback: got %h required 00000002", rd);
        end
        repeat (6) @(negedge CLK);
        core_finish(RES2);
        avl_read(2'd2, 4'd13, rd);
        n_cmp++;
        if (rd !== 32'h1) begin
            n_err++;
            $display("FAIL status_done: got %h required 00000001", rd);
        end
        avl_read(2'd2, 4'd8, rd);
        n_cmp++;
        if (rd !== 32'h0123_4567) begin
            n_err++;
            $display("FAIL result_w8: got %h required 01234567", rd);
        end
        avl_read(2'd2, 4'd11, rd);
        n_cmp++;
        if (rd !== 32'h7654_3210) begin
            n_err++;
            $display("FAIL result_w11: got %h required 76543210", rd);
        end
    endtask

    // Grants ch0, completes it, then accepts ch1 and leaves it BUSY.
    task automatic test_round_robin();
        bit ok;
        avl_write(2'd0, 4'd0, 32'hC000_0000, 4'hF);
        avl_write(2'd0, 4'd3, 32'h0000_ABCD, 4'hF);
        avl_write(2'd1, 4'd0, 32'hC100_0000, 4'hF);
        avl_write(2'd1, 4'd4, 32'h1111_2222, 4'hF);
        avl_write(2'd3, 4'd0, 32'hC300_0000, 4'hF);
        n_cmp++;
        if (EXPORT_DATA !== 32'hC000_ABCD) begin
            n_err++;
            $display("FAIL export_data: got %h required c000abcd", EXPORT_DATA);
        end
        avl_write(2'd0, 4'd12, 32'h1, 4'hF);
        avl_write(2'd3, 4'd12, 32'h1, 4'hF);
        avl_write(2'd1, 4'd12, 32'h1, 4'hF);
        n_cmp++;
        if (CORE_VALID !== 1'b1 || CORE_KEY[127:96] !== 32'hC000_0000 || CORE_MODE !== 1'b0) begin
            n_err++;
            $display("FAIL grant_first_ch0: valid=%b key_w0=%h mode=%b required 1/c0000000/0", CORE_VALID, CORE_KEY[127:96], CORE_MODE);
        end
        core_accept();
        n_cmp++;
        if (CORE_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL one_in_flight_ch0: valid=%b required 0", CORE_VALID);
        end
        repeat (2) @(negedge CLK);
        core_finish(128'h0);
        n_cmp++;
        if (CORE_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL valid_gap_after_done: valid=%b required 0", CORE_VALID);
        end
        @(negedge CLK);
        wait_valid(ok);
        n_cmp++;
        if (!ok || CORE_KEY[127:96] !== 32'hC100_0000) begin
            n_err++;
            $display("FAIL grant_second_ch1: valid=%b key_w0=%h required 1/c1000000", ok, CORE_KEY[127:96]);
        end
        core_accept();
    endtask

    task automatic test_werr();
        logic [31:0] rd;
        avl_write(2'd1, 4'd4, 32'hDEAD_BEEF, 4'hF);
        avl_read(2'd1, 4'd4, rd);
        n_cmp++;
        if (rd !== 32'h1111_2222) begin
            n_err++;
            $display("FAIL busy_write_dropped: got %h required 11112222", rd);
        end
        avl_read(2'd1, 4'd13, rd);
        n_cmp++;
        if (rd !== 32'hA) begin
            n_err++;
            $display("FAIL werr_set: got %h required 0000000a", rd);
        end
        avl_write(2'd1, 4'd13, 32'h8, 4'hF);
        avl_read(2'd1, 4'd13, rd);
        n_cmp++;
        if (rd !== 32'h2) begin
            n_err++;
            $display("FAIL werr_clear: got %h required 00000002", rd);
        end
        core_finish(128'h0);
    endtask

    // ch3 is granted last; READY coincides with a protected write to it.
    task automatic test_ready_vs_write();
        logic [31:0] rd;
        bit ok;
        n_cmp++;
        if (CORE_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL valid_gap_after_ch1: valid=%b required 0", CORE_VALID);
        end
        @(negedge CLK);
        wait_valid(ok);
        n_cmp++;
        if (!ok || CORE_KEY[127:96] !== 32'hC300_0000) begin
            n_err++;
            $display("FAIL grant_third_ch3: valid=%b key_w0=%h required 1/c3000000", ok, CORE_KEY[127:96]);
        end
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = {2'd3, 4'd0};
        AVL_WRITEDATA = 32'hFFFF_FFFF; AVL_BYTE_EN = 4'hF; CORE_READY = 1'b1;
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0; CORE_READY = 1'b0;
        $display("write ch3 w0 <= ffffffff with core ready");
        avl_read(2'd3, 4'd0, rd);
        n_cmp++;
        if (rd !== 32'hC300_0000) begin
            n_err++;
            $display("FAIL ready_write_dropped: got %h required c3000000", rd);
        end
        avl_read(2'd3, 4'd13, rd);
        n_cmp++;
        if (rd !== 32'hA) begin
            n_err++;
            $display("FAIL ready_write_werr: got %h required 0000000a", rd);
        end
        core_finish(RES3);
        avl_read(2'd3, 4'd13, rd);
        n_cmp++;
        if (rd !== 32'h9) begin
            n_err++;
            $display("FAIL ch3_status_done: got %h required 00000009", rd);
        end
        avl_read(2'd3, 4'd9, rd);
        n_cmp++;
        if (rd !== 32'h4444_4444) begin
            n_err++;
            $display("FAIL ch3_result_w9: got %h required 44444444", rd);
        end
    endtask

    task automatic test_irq();
        logic [31:0] rd;
        bit ok;
        avl_write(2'd0, 4'd12, 32'h5, 4'hF);
        wait_valid(ok);
        n_cmp++;
        if (!ok || CORE_KEY[127:96] !== 32'hC000_0000 || IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL irq_job_start: valid=%b key_w0=%h irq=%b required 1/c0000000/0", ok, CORE_KEY[127:96], IRQ);
        end
        core_accept();
        repeat (2) @(negedge CLK);
        AVL_CS = 1'b1; AVL_WRITE = 1'b1; AVL_ADDR = {2'd0, 4'd13};
        AVL_WRITEDATA = 32'h1; AVL_BYTE_EN = 4'hF;
        CORE_DONE = 1'b1; CORE_RESULT = RES2;
        @(negedge CLK);
        AVL_CS = 1'b0; AVL_WRITE = 1'b0; AVL_BYTE_EN = 4'h0; CORE_DONE = 1'b0;
        $display("core done with same-cycle DONE clear on ch0");
        n_cmp++;
        if (IRQ !== 1'b0) begin
            n_err++;
            $display("FAIL irq_latency_d1: irq=%b required 0", IRQ);
        end
        @(negedge CLK);
        n_cmp++;
        if (IRQ !== 1'b1) begin
            n_err++;
            $display("FAIL irq_latency_d2: irq=%b required 1", IRQ);
        end
        avl_read(2'd0, 4'd13, rd);
        n_cmp++;
        if (rd !== 32'h1) begin
            n_err++;
            $display("FAIL done_set_wins: got %h required 00000001", rd);
        end
        avl_read(2'd2, 4'd15, rd);
        n_cmp++;
        if (rd !== 32'h1) begin
            n_err++;
            $display("FAIL irq_summary: got %h required 00000001", rd);
        end
    endtask

    task automatic test_reset_midwait();
        logic [31:0] rd;
        bit ok;
        avl_write(2'd2, 4'd12, 32'h3, 4'hF);
        wait_valid(ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL rst_job_request: valid=%b required 1", ok);
        end
        core_accept();
        repeat (2) @(negedge CLK);
        RESET_N = 1'b0;
        #1;
        n_cmp++;
        if (IRQ !== 1'b0 || EXPORT_DATA !== 32'h0 || CORE_KEY !== 128'h0 || CORE_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL async_reset: irq=%b export=%h key=%h valid=%b required all 0", IRQ, EXPORT_DATA, CORE_KEY, CORE_VALID);
        end
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        core_finish(RES3);
        avl_read(2'd2, 4'd8, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL done_after_reset_ignored: w8=%h required 00000000", rd);
        end
        avl_read(2'd2, 4'd13, rd);
        n_cmp++;
        if (rd !== 32'h0) begin
            n_err++;
            $display("FAIL status_after_reset: got %h required 00000000", rd);
        end
        avl_read(2'd2, 4'd0, rd);
        n_cmp++;
        if (rd !== 32'h0 || IRQ !== 1'b0 || CORE_VALID !== 1'b0) begin
            n_err++;
            $display("FAIL state_after_reset: key_w0=%h irq=%b valid=%b required 0/0/0", rd, IRQ, CORE_VALID);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        RESET_N = 1'b0;
        AVL_READ = 1'b0; AVL_WRITE = 1'b0; AVL_CS = 1'b0;
        AVL_BYTE_EN = 4'h0; AVL_ADDR = '0; AVL_WRITEDATA = '0;
        CORE_READY = 1'b0; CORE_DONE = 1'b0; CORE_RESULT = '0;
        repeat (3) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        test_reset();
        test_byte_enable();
        test_single_job();
        test_round_robin();
        test_werr();
        test_ready_vs_write();
        test_irq();
        test_reset_midwait();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
